// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction width, default reset PC and the
// fetch-entry payload handed from fetch to decode.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with a flush input; DEPTH must be a power of two.
// Storage is not reset: the empty flag qualifies the read data.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Flush wins over any concurrent push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and queues
// {pc, instr, pc+4} for decode. Optional macro FETCH_ALIGN_CHECK_EN enables fetch_err.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned IM_ADDR_W = 10,
    parameter int unsigned FQ_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [IM_ADDR_W-1:0] im_addr,
    input  logic [INSTR_W-1:0]   im_dout,
    input  logic                 redirect_valid,
    input  logic [AW-1:0]        redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [AW-1:0]        out_pc,
    output logic [AW-1:0]        out_pc4,
    output logic                 fetch_err
);

    localparam int unsigned ENTRY_W = 2 * AW + INSTR_W;

    logic [AW-1:0]      pc;
    logic [AW-1:0]      pc_plus4;
    logic               pop;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [AW-1:0]      head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [AW-1:0]      head_pc4;

    assign pc_plus4 = pc + AW'(4);
    assign im_addr  = pc[IM_ADDR_W+1:2];
    assign pop      = out_valid & out_ready;
    assign push     = ~redirect_valid & (~fifo_full | pop);

    fetch_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FQ_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(redirect_valid),
        .push (push),
        .wdata({pc, im_dout, pc_plus4}),
        .pop  (pop),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Head fields are forced to zero while the queue is empty.
    assign {head_pc, head_instr, head_pc4} = head;
    assign out_valid = ~fifo_empty;
    assign out_pc    = out_valid ? head_pc    : '0;
    assign out_instr = out_valid ? head_instr : '0;
    assign out_pc4   = out_valid ? head_pc4   : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= AW'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= {redirect_pc[AW-1:2], 2'b00};
        end else if (push) begin
            pc <= pc_plus4;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;

    // Sticky until reset; the fetch itself still uses the aligned target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign fetch_err           = 1'b0;
`endif

endmodule
